// File: rtl/sig_check_if.sv
// Bus between the cond-chain result stream / control and the signature checker.
interface sig_check_if #(
  parameter int PAR_DATA_BITS = 16,
  parameter int PAR_CNT_BITS  = 8
);
  logic                     ib_start;
  logic                     ib_abort;
  logic [PAR_CNT_BITS-1:0]  ivG_len;
  logic [PAR_DATA_BITS-1:0] ivG_expect;
  logic                     ib_valid;
  logic [PAR_DATA_BITS-1:0] ivG_data;
  logic                     ob_busy;
  logic                     ob_done;
  logic                     ob_match;
  logic [PAR_DATA_BITS-1:0] ovG_sig;
  logic [PAR_CNT_BITS-1:0]  ovG_count;

  modport master (
    output ib_start, ib_abort, ivG_len, ivG_expect, ib_valid, ivG_data,
    input  ob_busy, ob_done, ob_match, ovG_sig, ovG_count
  );

  modport slave (
    input  ib_start, ib_abort, ivG_len, ivG_expect, ib_valid, ivG_data,
    output ob_busy, ob_done, ob_match, ovG_sig, ovG_count
  );
endinterface

// File: rtl/sig_check.sv
// Folds a window of result words into a rotate-XOR signature and
// compares it with an expected value, pulsing done for one cycle.
module sig_check #(
  parameter int                       PAR_DATA_BITS = 16,
  parameter int                       PAR_CNT_BITS  = 8,
  parameter logic [PAR_DATA_BITS-1:0] PAR_SEED      = 16'hFFFF
) (
  input logic        ib_clk,
  input logic        ib_rst,
  sig_check_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [PAR_DATA_BITS-1:0] sig_q, sig_d;
  logic [PAR_DATA_BITS-1:0] exp_q, exp_d;
  logic [PAR_CNT_BITS-1:0]  count_q, count_d;
  logic [PAR_CNT_BITS-1:0]  len_q, len_d;
  logic                     match_q, match_d;
  logic                     busy, done;

  // word acceptance: only in RUN, and abort wins over a same-cycle valid
  logic accept;
  assign accept = (state_q == RUN) && !bus.ib_abort && bus.ib_valid;

  // state register
  always_ff @(posedge ib_clk) begin
    if (ib_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.ib_start) state_d = (bus.ivG_len == '0) ? DONE : RUN;
      RUN: begin
        if (bus.ib_abort)                                 state_d = IDLE;
        else if (accept && (count_q + 1'b1) == len_q)     state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

  // datapath next values; match is captured on the edge that enters DONE
  // so it is already valid in the done cycle
  always_comb begin
    sig_d   = sig_q;
    exp_d   = exp_q;
    count_d = count_q;
    len_d   = len_q;
    match_d = match_q;
    if (state_q == IDLE && bus.ib_start) begin
      sig_d   = PAR_SEED;
      count_d = '0;
      len_d   = bus.ivG_len;
      exp_d   = bus.ivG_expect;
      match_d = 1'b0;
    end else if (state_q == RUN && bus.ib_abort) begin
      match_d = 1'b0;
    end else if (accept) begin
      sig_d   = {sig_q[PAR_DATA_BITS-2:0], sig_q[PAR_DATA_BITS-1]} ^ bus.ivG_data;
      count_d = count_q + 1'b1;
    end
    if (state_d == DONE && state_q != DONE) match_d = (sig_d == exp_d);
  end

  // datapath registers
  always_ff @(posedge ib_clk) begin
    if (ib_rst) begin
      sig_q   <= PAR_SEED;
      exp_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      match_q <= 1'b0;
    end else begin
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      count_q <= count_d;
      len_q   <= len_d;
      match_q <= match_d;
    end
  end

  assign bus.ob_busy   = busy;
  assign bus.ob_done   = done;
  assign bus.ob_match  = match_q;
  assign bus.ovG_sig   = sig_q;
  assign bus.ovG_count = count_q;

endmodule

// File: doc/sig_check.md
Name: sig_check

Overview:
- Downstream consumer of the cond-stage datapath. Folds a programmable-length window of 16-bit result words into a rotate-XOR signature.
- Compares the final signature against an expected value and reports pass/fail with a one-cycle done pulse.
- Used as the self-check stage on the datapath output (ovG_data of the chain drives ivG_data here).

Parameters:
- PAR_DATA_BITS, 16, width of data, signature, seed and expected value.
- PAR_CNT_BITS, 8, width of window length and word counter.
- PAR_SEED, 16'hFFFF, signature initial value loaded on start (PAR_DATA_BITS wide).

Ports:
- ib_clk  in  1  clock, all logic on rising edge.
- ib_rst  in  1  synchronous active-high reset.
- ib_start  in  1  start a window; sampled only in IDLE.
- ib_abort  in  1  abandon window; sampled only in RUN.
- ivG_len  in  PAR_CNT_BITS  words in window; latched on accepted start.
- ivG_expect  in  PAR_DATA_BITS  expected signature; latched on accepted start.
- ib_valid  in  1  ivG_data qualifier.
- ivG_data  in  PAR_DATA_BITS  result word from upstream cond chain.
- ob_busy  out  1  high in RUN and DONE.
- ob_done  out  1  one-cycle pulse, window complete.
- ob_match  out  1  registered compare result; valid from ob_done, held until next accepted start.
- ovG_sig  out  PAR_DATA_BITS  running/final signature; holds after done.
- ovG_count  out  PAR_CNT_BITS  words accepted in current/last window.

Behaviour:
- Reset (ib_rst=1 at clock edge):
  - state=IDLE, ovG_sig=PAR_SEED, ovG_count=0, ob_busy=0, ob_done=0, ob_match=0.
  - Latched len/expect cleared to 0.
  - Reset mid-window abandons it; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - ib_valid is ignored.
  - ib_start=1 loads ovG_sig=PAR_SEED, ovG_count=0, ob_match=0, latches len and expect.
  - Next state is DONE if ivG_len==0, else RUN.
- RUN:
  - Word accepted on each edge where ib_valid=1.
  - On acceptance: sig <= {sig[N-2:0], sig[N-1]} ^ ivG_data (rotate left 1, then XOR); count <= count+1.
  - When the accepted word makes count==len: next state DONE.
  - ib_valid=0: sig and count hold.
  - ib_start is ignored in RUN.
- Abort:
  - ib_abort=1 in RUN returns to IDLE next cycle.
  - No done pulse; ob_match=0; sig and count hold their partial values.
  - Abort has priority over a same-cycle ib_valid (that word is not accepted).
- DONE:
  - Single cycle with ob_done=1 and ob_match=(sig==expect), registered on DONE entry so both are valid in that same cycle.
  - Always returns to IDLE.
  - ib_start, ib_valid and ib_abort are all ignored in DONE.
- Latency:
  - ob_done asserts on the cycle after the edge that accepts the last word.
  - For len=0, ob_done asserts the cycle after start.
  - Back-to-back windows: the earliest next start is sampled in the first IDLE cycle after DONE.
- ob_busy is combinational from state: 1 in RUN and DONE.
- Counter width:
  - len max is 2^PAR_CNT_BITS-1.
  - count never wraps because the window ends at len.
- Arithmetic is pure bitwise; there is no carry anywhere.

Test Plan:
- Reset with all inputs active -> ob_busy=0, ob_done=0, ob_match=0, ovG_sig=16'hFFFF, ovG_count=0 on the first cycle after reset.
- PAR_SEED=0, len=2, expect=16'h0000, words 16'h0001 then 16'h0002 on consecutive cycles -> sig 0001 then 0000; ob_done pulse 1 cycle after the second word; ob_match=1; ovG_count=2.
- PAR_SEED=0, len=2, expect=16'h1234, words 16'h8000 then 16'h0000 with one ib_valid=0 gap between them -> sig 8000, held through the gap, then 0001; ob_match=0; done 1 cycle after the second accepted word.
- len=0, expect=16'hFFFF (default seed), start -> ob_done on the next cycle with ob_match=1; ovG_count=0.
- len=3, abort after one word together with ib_valid=1 -> no ob_done, back to IDLE, ovG_count=1; a new start with len=1 then completes normally.
- ib_start pulsed during RUN and during DONE, and ib_valid during IDLE -> no effect on sig, count or len; reset asserted mid-RUN -> IDLE with reset values and no done.
